// File: rtl/minicpu_irq_pkg.sv
// Shared definitions for the MiniCPU interrupt controller.
//  - Register offsets within the four-byte register window.
//  - FSM state encodings for the Int/Ack/Vector handshake.
//  - vec_of(): vector address for a given interrupt id.
package minicpu_irq_pkg;

    localparam logic [1:0] REG_IMR  = 2'd0;
    localparam logic [1:0] REG_IPR  = 2'd1;
    localparam logic [1:0] REG_ISR  = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WVP  = 2'd2
    } irq_state_e;

    // IRQ n vectors sit just below the default vector, two bytes apart.
    function automatic logic [15:0] vec_of(input logic [2:0] id, input logic [15:0] vec_base);
        return vec_base - {12'd0, id, 1'b0} - 16'd2;
    endfunction

endpackage

// File: rtl/minicpu_irq_prio.sv
// Fixed-priority encoder: the lowest set index wins.
// Ports:
//  req    in   N   request vector
//  valid  out  1   at least one request bit set
//  id     out  3   index of the lowest set bit (0 when none)
module minicpu_irq_prio #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [2:0]   id
);

    // Scan from the top so that the lowest set index is written last.
    always_comb begin
        valid = |req;
        id    = 3'd0;
        for (int i = N - 1; i >= 0; i--) begin
            id = req[i] ? 3'(i) : id;
        end
    end

endmodule

// File: rtl/minicpu_irq_ctrl.sv
// Prioritised interrupt controller for the MiniCPU core.
// Latches rising edges of up to 8 request lines, masks them, and schedules
// the highest-priority eligible one onto the core's Int/Ack/Vector handshake.
// Nesting is allowed only above the highest level currently in service.
// Build option: define MINICPU_IRQ_SYNC_EN to pass Irq through a 2-flop
// synchroniser before edge detection (adds 2 Clk of latency).
// Ports:
//  Clk, Rst        clock, synchronous active-high reset
//  Irq             request lines (rising edge sets pending)
//  Int, Ack, VP    handshake with the core
//  Vector          vector address presented to the core
//  Wr, Rd, MAO     bus strobes and address
//  MDO             bus write data
//  RDO, RSel       register read data and read-select
module minicpu_irq_ctrl
    import minicpu_irq_pkg::*;
#(
    parameter int          N_IRQ     = 8,
    parameter logic [15:0] BASE_ADDR = 16'hFFF0,
    parameter logic [15:0] VEC_BASE  = 16'hFFFE
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [N_IRQ-1:0] Irq,
    output logic             Int,
    input  logic             Ack,
    input  logic             VP,
    output logic [15:0]      Vector,
    input  logic             Wr,
    input  logic             Rd,
    input  logic [15:0]      MAO,
    input  logic [7:0]       MDO,
    output logic [7:0]       RDO,
    output logic             RSel
);

    localparam logic [7:0] IMPL_MASK = 8'hFF >> (8 - N_IRQ);

    logic [7:0]  imr_q, imr_d, ipr_q, ipr_d, isr_q, isr_d;
    logic [7:0]  irq_hist_q, irq_hist_d;
    irq_state_e  state_q, state_d;
    logic [2:0]  id_q, id_d;
    logic [15:0] vector_q, vector_d;
    logic        int_q, int_d;

    logic [7:0]  irq_ext_s, irq_in_s, rise_s, cand_s;
    logic [7:0]  w1c_s, ack_clr_s, eoi_clr_s;
    logic [15:0] off_s;
    logic        in_rng_s, wr_sel_s, ack_take_s;
    logic        cand_valid_s, isr_valid_s, eligible_s, still_ok_s;
    logic [2:0]  cand_id_s, isr_id_s;
    logic [7:0]  rdo_s;

    // Widen the request lines to the internal 8-bit register width.
    always_comb begin
        irq_ext_s           = 8'h00;
        irq_ext_s[N_IRQ-1:0] = Irq;
    end

`ifdef MINICPU_IRQ_SYNC_EN
    logic [7:0] sync1_q, sync2_q;
    logic [7:0] sync1_d, sync2_d;
    assign sync1_d = irq_ext_s;
    assign sync2_d = sync1_q;

    // Two-stage synchroniser for asynchronous request sources.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end
    assign irq_in_s = sync2_q;
`else
    assign irq_in_s = irq_ext_s;
`endif

    assign irq_hist_d = irq_in_s;
    assign rise_s     = irq_in_s & ~irq_hist_q;

    // Register window decode; subtraction avoids overflow at the top of memory.
    assign off_s    = MAO - BASE_ADDR;
    assign in_rng_s = (off_s[15:2] == 14'd0);
    assign wr_sel_s = Wr && in_rng_s;
    assign RSel     = Rd && in_rng_s;

    assign cand_s = ipr_q & imr_q;

    minicpu_irq_prio #(.N(N_IRQ)) u_prio_cand (
        .req   (cand_s[N_IRQ-1:0]),
        .valid (cand_valid_s),
        .id    (cand_id_s)
    );

    minicpu_irq_prio #(.N(N_IRQ)) u_prio_isr (
        .req   (isr_q[N_IRQ-1:0]),
        .valid (isr_valid_s),
        .id    (isr_id_s)
    );

    // Nesting limit: only strictly higher priority than the lowest in-service index.
    assign eligible_s = cand_valid_s && (!isr_valid_s || (cand_id_s < isr_id_s));
    assign still_ok_s = cand_s[id_q] && (!isr_valid_s || (id_q < isr_id_s));
    assign ack_take_s = (state_q == ST_REQ) && Ack;

    // Register-side next-state: mask writes, W1C, Ack and EOI updates.
    always_comb begin
        w1c_s     = 8'h00;
        eoi_clr_s = 8'h00;
        imr_d     = imr_q;
        ack_clr_s = ack_take_s ? (8'h01 << id_q) : 8'h00;
        if (wr_sel_s) begin
            case (off_s[1:0])
                REG_IMR: imr_d     = MDO & IMPL_MASK;
                REG_IPR: w1c_s     = MDO;
                REG_ISR: eoi_clr_s = isr_valid_s ? (8'h01 << isr_id_s) : 8'h00;
                default: imr_d     = imr_q;
            endcase
        end else begin
            imr_d = imr_q;
        end
        // A new edge wins over any same-cycle clear.
        ipr_d = ((ipr_q & ~w1c_s & ~ack_clr_s) | rise_s) & IMPL_MASK;
        isr_d = ((isr_q & ~eoi_clr_s) | ack_clr_s) & IMPL_MASK;
    end

    // Handshake FSM: IDLE -> REQ -> WVP -> IDLE; Ack beats cancel in REQ.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        vector_d = vector_q;
        int_d    = int_q;
        case (state_q)
            ST_IDLE: begin
                if (eligible_s) begin
                    id_d     = cand_id_s;
                    vector_d = vec_of(cand_id_s, VEC_BASE);
                    int_d    = 1'b1;
                    state_d  = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (Ack) begin
                    int_d   = 1'b0;
                    state_d = ST_WVP;
                end else if (!still_ok_s) begin
                    int_d    = 1'b0;
                    vector_d = VEC_BASE;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_WVP: begin
                if (VP) begin
                    vector_d = VEC_BASE;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_WVP;
                end
            end
            default: begin
                int_d    = 1'b0;
                vector_d = VEC_BASE;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and register flops with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            imr_q      <= 8'h00;
            ipr_q      <= 8'h00;
            isr_q      <= 8'h00;
            irq_hist_q <= 8'h00;
            state_q    <= ST_IDLE;
            id_q       <= 3'd0;
            vector_q   <= VEC_BASE;
            int_q      <= 1'b0;
        end else begin
            imr_q      <= imr_d;
            ipr_q      <= ipr_d;
            isr_q      <= isr_d;
            irq_hist_q <= irq_hist_d;
            state_q    <= state_d;
            id_q       <= id_d;
            vector_q   <= vector_d;
            int_q      <= int_d;
        end
    end

    // Read mux; returns zero whenever the block is not selected.
    always_comb begin
        rdo_s = 8'h00;
        if (RSel) begin
            case (off_s[1:0])
                REG_IMR:  rdo_s = imr_q;
                REG_IPR:  rdo_s = ipr_q;
                REG_ISR:  rdo_s = isr_q;
                REG_STAT: rdo_s = {int_q, 3'b000, (state_q != ST_IDLE), id_q};
                default:  rdo_s = 8'h00;
            endcase
        end else begin
            rdo_s = 8'h00;
        end
    end

    assign RDO    = rdo_s;
    assign Int    = int_q;
    assign Vector = vector_q;

endmodule
